alu_branch_unit: RTL and testbench
==================================

Name: alu_branch_unit

Overview:
- Execute-stage datapath block of the multi-cycle MIPS core.
- Selects ALU operand A (register value or shift amount), performs the ALU operation, and produces result, HI/LO, overflow and zero flags.
- In a separate branch step, computes the next PC from the zero flag and the sign-extended immediate.
- Sits between the register file / decoder and the memory / writeback / PC-update logic of the control FSM.

Parameters:
- XLEN, 32, datapath width; the only supported value is 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  execute strobe; operands sampled and result registered this cycle
- alu_control  in  4  operation code (see Behaviour)
- read_data1  in  32  rs value
- shamt  in  5  instruction shift amount
- select_shamt  in  1  1: srcA = zero-extended shamt; 0: srcA = read_data1
- src_b  in  32  operand B (rt or extended immediate, muxed upstream)
- branch_en  in  1  branch-resolve strobe
- branch  in  1  instruction is a branch (beq)
- imm  in  32  sign-extended branch offset, in words
- pc  in  32  already-incremented PC (word address)
- alu_result  out  32  registered result
- hi  out  32  registered HI
- lo  out  32  registered LO
- overflow  out  1  registered signed overflow flag
- alu_zero  out  1  registered (alu_result == 0)
- alu_done  out  1  one-cycle pulse, the cycle after en
- pc_out  out  32  registered next PC
- branch_done  out  1  one-cycle pulse, the cycle after branch_en

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0. Reset has priority over en and branch_en and aborts any in-flight operation.
- srcA mux is combinational: srcA = select_shamt ? {27'b0,shamt} : read_data1.
- On en=1, registered on the same edge:
  - alu_result, alu_zero and overflow are updated.
  - hi/lo change only for multiply/divide codes; otherwise they hold.
  - alu_done=1 the following cycle, then 0 unless en is held.
- With en=0, all results hold and alu_done=0. Back-to-back en is allowed; each produces its own done pulse.
- alu_control codes:
  - 0000 AND; 0001 OR; 0010 ADD (signed overflow flagged); 0011 ADDU (overflow=0)
  - 0100 SLL: src_b << srcA[4:0]
  - 0101 SRL: logical shift of src_b by srcA[4:0]
  - 0110 SUB, signed overflow flagged
  - 0111 SLT, signed compare, result 0 or 1
  - 1000 MULT: signed 64-bit product, hi=[63:32], lo=[31:0]; alu_result=lo
  - 1001 DIV: only when ALU_DIV_EN is defined; otherwise treated as undefined
  - 1010 XOR; 1011 NOR
  - 1100 SRA: arithmetic shift of src_b by srcA[4:0]
  - 1101 SLTU, unsigned compare
  - 1110 SUBU (overflow=0)
  - 1111 LUI: src_b << 16
- Undefined codes produce result 0 and overflow 0.
- Overflow is set only for ADD/SUB, and the result is still written (no trap).
- Shift amounts use only srcA[4:0]; the upper bits are ignored.
- Arithmetic is modulo 2^32 (wrap-around).
- Branch: on branch_en=1, pc_out <= (branch & alu_zero) ? pc + imm : pc, modulo 2^32 (negative imm wraps); branch_done pulses the next cycle.
  - alu_zero is the registered value from the most recent en.
  - If branch_en and en coincide, the branch uses the old (pre-update) alu_zero.
- With branch_en=0, pc_out holds.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: code 1001 = signed divide, single-cycle; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend, alu_result = lo.
  - Divide by zero: lo = 32'hFFFFFFFF, hi = srcA.
  - 0x80000000 / -1: lo = 0x80000000, hi = 0.
- Undefined: code 1001 behaves as undefined (result 0, hi/lo unchanged).

Decomposition:
- Shared package alu_pkg: the 4-bit operation-code localparams (ALU_AND … ALU_LUI), XLEN, and a typedef for the opcode.
- One natural sub-module: alu_src_a_sel (the combinational srcA mux).
- The branch PC logic stays inline in the top.

Test Plan:
- Reset with en=1 asserted → all outputs 0; then ADD 0x7FFFFFFF+1 → alu_result=0x80000000, overflow=1, alu_done pulses 1 cycle later.
- SUB 5-5 → alu_result=0, alu_zero=1; then branch_en with branch=1, pc=0x10, imm=0xFFFFFFFC → pc_out=0x0C, branch_done pulses.
- select_shamt=1, shamt=4, SRA on src_b=0xF0000000 → 0xFF000000; SRL → 0x0F000000; read_data1=0xFFFFFF24 with select_shamt=0, SLL of 1 → 0x10 (bits [4:0]=4 only).
- MULT srcA=-3, src_b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; a following ADD leaves hi/lo unchanged.
- branch=1 with alu_zero=0, pc=0x20 → pc_out=0x20; en held high for 3 cycles → 3 distinct results, alu_done high for 3 consecutive cycles.
- With ALU_DIV_EN: -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; 9 / 0 → lo=0xFFFFFFFF, hi=9. Without ALU_DIV_EN: code 1001 → result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared datapath width and ALU operation codes for the execute stage
package alu_pkg;

    // The datapath is fixed at 32 bits; shift and LUI logic assume it.
    localparam int XLEN = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'b0000;
    localparam alu_op_t ALU_OR   = 4'b0001;
    localparam alu_op_t ALU_ADD  = 4'b0010;
    localparam alu_op_t ALU_ADDU = 4'b0011;
    localparam alu_op_t ALU_SLL  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SUB  = 4'b0110;
    localparam alu_op_t ALU_SLT  = 4'b0111;
    localparam alu_op_t ALU_MULT = 4'b1000;
    localparam alu_op_t ALU_DIV  = 4'b1001;
    localparam alu_op_t ALU_XOR  = 4'b1010;
    localparam alu_op_t ALU_NOR  = 4'b1011;
    localparam alu_op_t ALU_SRA  = 4'b1100;
    localparam alu_op_t ALU_SLTU = 4'b1101;
    localparam alu_op_t ALU_SUBU = 4'b1110;
    localparam alu_op_t ALU_LUI  = 4'b1111;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_src_a_sel.sv
// rtl/alu_src_a_sel.sv - operand A select between rs value and zero-extended shift amount
module alu_src_a_sel
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] read_data1,
    input  logic [4:0]      shamt,
    input  logic            select_shamt,
    output logic [XLEN-1:0] src_a
);

    always_comb begin
        src_a = read_data1;
        if (select_shamt) begin
            src_a = {{(XLEN-5){1'b0}}, shamt};
        end
    end

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - execute-stage ALU with HI/LO and branch next-PC; ALU_DIV_EN enables signed divide
module alu_branch_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] read_data1,
    input  logic [4:0]      shamt,
    input  logic            select_shamt,
    input  logic [XLEN-1:0] src_b,
    input  logic            branch_en,
    input  logic            branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            overflow,
    output logic            alu_zero,
    output logic            alu_done,
    output logic [XLEN-1:0] pc_out,
    output logic            branch_done
);

    logic [XLEN-1:0] src_a;
    logic [4:0]      shift_amt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic signed [2*XLEN-1:0] product;

    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            ovf_q, ovf_d;
    logic            zero_q;
    logic            done_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            bdone_q;

    alu_src_a_sel u_src_a_sel (
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .src_a        (src_a)
    );

    assign shift_amt = src_a[4:0];
    assign sum       = src_a + src_b;
    assign diff      = src_a - src_b;
    // Sign-extend both operands to full width so the low 2*XLEN bits are the signed product.
    assign product   = $signed({{XLEN{src_a[XLEN-1]}}, src_a}) *
                       $signed({{XLEN{src_b[XLEN-1]}}, src_b});

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (alu_control)
            ALU_AND:  result_d = src_a & src_b;
            ALU_OR:   result_d = src_a | src_b;
            ALU_ADD: begin
                result_d = sum;
                ovf_d    = signed_ovf(src_a[XLEN-1], src_b[XLEN-1], sum[XLEN-1]);
            end
            ALU_ADDU: result_d = sum;
            ALU_SLL:  result_d = src_b << shift_amt;
            ALU_SRL:  result_d = src_b >> shift_amt;
            ALU_SUB: begin
                result_d = diff;
                // Subtraction overflows when operands differ in sign, so invert B's sign.
                ovf_d    = signed_ovf(src_a[XLEN-1], ~src_b[XLEN-1], diff[XLEN-1]);
            end
            ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_MULT: begin
                hi_d     = product[2*XLEN-1:XLEN];
                lo_d     = product[XLEN-1:0];
                result_d = product[XLEN-1:0];
            end
`ifdef ALU_DIV_EN
            ALU_DIV: begin
                if (src_b == '0) begin
                    lo_d = '1;
                    hi_d = src_a;
                end else if (src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == '1) begin
                    lo_d = src_a;
                    hi_d = '0;
                end else begin
                    lo_d = $signed(src_a) / $signed(src_b);
                    hi_d = $signed(src_a) % $signed(src_b);
                end
                result_d = lo_d;
            end
`endif
            ALU_XOR:  result_d = src_a ^ src_b;
            ALU_NOR:  result_d = ~(src_a | src_b);
            ALU_SRA:  result_d = $signed(src_b) >>> shift_amt;
            ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SUBU: result_d = diff;
            ALU_LUI:  result_d = {src_b[15:0], 16'h0000};
            default: begin
                result_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    // Branch resolves against the zero flag already registered, never the one being computed.
    always_comb begin
        pc_d = pc;
        if (branch && zero_q) begin
            pc_d = pc + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            pc_q     <= '0;
            bdone_q  <= 1'b0;
        end else begin
            done_q  <= en;
            bdone_q <= branch_en;
            if (en) begin
                result_q <= result_d;
                zero_q   <= (result_d == '0);
                ovf_q    <= ovf_d;
                hi_q     <= hi_d;
                lo_q     <= lo_d;
            end
            if (branch_en) begin
                pc_q <= pc_d;
            end
        end
    end

    assign alu_result  = result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign overflow    = ovf_q;
    assign alu_zero    = zero_q;
    assign alu_done    = done_q;
    assign pc_out      = pc_q;
    assign branch_done = bdone_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - self-checking bench for alu_branch_unit with a reference model
module tb_alu_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  alu_control;
    logic [31:0] read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    logic [31:0] src_b;
    logic        branch_en;
    logic        branch;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_result, hi, lo, pc_out;
    logic        overflow, alu_zero, alu_done, branch_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_res, m_hi, m_lo, m_pc;
    logic        m_ovf, m_zero, m_done, m_bdone;

    localparam longint MAX_S32 = 64'sd2147483647;
    localparam longint MIN_S32 = -64'sd2147483648;

    alu_branch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .alu_control  (alu_control),
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .src_b        (src_b),
        .branch_en    (branch_en),
        .branch       (branch),
        .imm          (imm),
        .pc           (pc),
        .alu_result   (alu_result),
        .hi           (hi),
        .lo           (lo),
        .overflow     (overflow),
        .alu_zero     (alu_zero),
        .alu_done     (alu_done),
        .pc_out       (pc_out),
        .branch_done  (branch_done)
    );

    always #5 clk = ~clk;

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o, output logic hl,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; o = 0; hl = 0; h = 0; l = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0]; o = (s > MAX_S32) || (s < MIN_S32); end
            4'd3:  r = a + b;
            4'd4:  r = b << a[4:0];
            4'd5:  r = b >> a[4:0];
            4'd6:  begin s = sa - sb; r = s[31:0]; o = (s > MAX_S32) || (s < MIN_S32); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  begin s = sa * sb; h = s[63:32]; l = s[31:0]; r = l; hl = 1; end
`ifdef ALU_DIV_EN
            4'd9: begin
                hl = 1;
                if (b == 0) begin l = 32'hFFFFFFFF; h = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = 32'h80000000; h = 0; end
                else begin s = sa / sb; l = s[31:0]; s = sa % sb; h = s[31:0]; end
                r = l;
            end
`endif
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: begin s = sb >>> a[4:0]; r = s[31:0]; end
            4'd13: r = (a < b) ? 32'd1 : 32'd0;
            4'd14: r = a - b;
            4'd15: r = b * 32'd65536;
            default: r = 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic step_model();
        logic [31:0] a, r, h, l;
        logic o, hl;
        if (rst) begin
            m_res = 0; m_hi = 0; m_lo = 0; m_pc = 0;
            m_ovf = 0; m_zero = 0; m_done = 0; m_bdone = 0;
        end else begin
            if (branch_en) m_pc = (branch && m_zero) ? pc + imm : pc;
            m_bdone = branch_en;
            m_done  = en;
            if (en) begin
                a = select_shamt ? {27'd0, shamt} : read_data1;
                ref_alu(alu_control, a, src_b, r, o, hl, h, l);
                m_res = r; m_ovf = o; m_zero = (r == 0);
                if (hl) begin m_hi = h; m_lo = l; end
            end
        end
    endtask

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic sel,
                          input logic [4:0] sh, input logic [31:0] b);
        alu_control = op; read_data1 = a; select_shamt = sel; shamt = sh; src_b = b;
    endtask

    task automatic test_reset();
        set_op(4'd2, 32'd5, 1'b0, 5'd0, 32'd7);
        en = 1; branch_en = 1; branch = 1; pc = 32'h44; imm = 32'h8; rst = 1;
        tick(); tick();
        checks += 8;
        if (alu_result !== 0) begin errors++; $display("FAIL reset_result got %h want 0", alu_result); end
        if (hi !== 0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        if (lo !== 0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        if (overflow !== 0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (alu_zero !== 0) begin errors++; $display("FAIL reset_zero got %b want 0", alu_zero); end
        if (alu_done !== 0) begin errors++; $display("FAIL reset_done got %b want 0", alu_done); end
        if (pc_out !== 0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
        if (branch_done !== 0) begin errors++; $display("FAIL reset_bdone got %b want 0", branch_done); end
        rst = 0; en = 0; branch_en = 0; branch = 0;
    endtask

    task automatic test_add_overflow();
        set_op(4'd2, 32'h7FFFFFFF, 1'b0, 5'd0, 32'd1);
        en = 1; tick(); en = 0;
        checks += 4;
        if (alu_result !== 32'h80000000) begin errors++; $display("FAIL add_result got %h want 80000000", alu_result); end
        if (overflow !== 1) begin errors++; $display("FAIL add_ovf got %b want 1", overflow); end
        if (alu_zero !== 0) begin errors++; $display("FAIL add_zero got %b want 0", alu_zero); end
        if (alu_done !== 1) begin errors++; $display("FAIL add_done got %b want 1", alu_done); end
        tick();
        checks += 2;
        if (alu_done !== 0) begin errors++; $display("FAIL add_done_drop got %b want 0", alu_done); end
        if (alu_result !== 32'h80000000) begin errors++; $display("FAIL add_hold got %h want 80000000", alu_result); end
    endtask

    task automatic test_sub_branch();
        set_op(4'd6, 32'd5, 1'b0, 5'd0, 32'd5);
        en = 1; tick(); en = 0;
        checks += 3;
        if (alu_result !== 0) begin errors++; $display("FAIL sub_result got %h want 0", alu_result); end
        if (alu_zero !== 1) begin errors++; $display("FAIL sub_zero got %b want 1", alu_zero); end
        if (overflow !== 0) begin errors++; $display("FAIL sub_ovf got %b want 0", overflow); end
        branch_en = 1; branch = 1; pc = 32'h10; imm = 32'hFFFFFFFC;
        tick(); branch_en = 0;
        checks += 2;
        if (pc_out !== 32'h0C) begin errors++; $display("FAIL br_taken_pc got %h want 0000000c", pc_out); end
        if (branch_done !== 1) begin errors++; $display("FAIL br_done got %b want 1", branch_done); end
        pc = 32'h99;
        tick();
        checks += 2;
        if (branch_done !== 0) begin errors++; $display("FAIL br_done_drop got %b want 0", branch_done); end
        if (pc_out !== 32'h0C) begin errors++; $display("FAIL br_hold got %h want 0000000c", pc_out); end
    endtask

    task automatic test_shifts();
        en = 1;
        set_op(4'd12, 32'hDEADBEEF, 1'b1, 5'd4, 32'hF0000000); tick();
        checks++;
        if (alu_result !== 32'hFF000000) begin errors++; $display("FAIL sra got %h want ff000000", alu_result); end
        set_op(4'd5, 32'hDEADBEEF, 1'b1, 5'd4, 32'hF0000000); tick();
        checks++;
        if (alu_result !== 32'h0F000000) begin errors++; $display("FAIL srl got %h want 0f000000", alu_result); end
        set_op(4'd4, 32'hFFFFFF24, 1'b0, 5'd31, 32'd1); tick();
        checks++;
        if (alu_result !== 32'h10) begin errors++; $display("FAIL sll_low5 got %h want 00000010", alu_result); end
        set_op(4'd15, 32'd0, 1'b0, 5'd0, 32'h1234ABCD); tick();
        checks++;
        if (alu_result !== 32'hABCD0000) begin errors++; $display("FAIL lui got %h want abcd0000", alu_result); end
        en = 0;
    endtask

    task automatic test_mult_hold();
        en = 1;
        set_op(4'd8, 32'hFFFFFFFD, 1'b0, 5'd0, 32'd7); tick();
        checks += 3;
        if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
        if (alu_result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_res got %h want ffffffeb", alu_result); end
        set_op(4'd2, 32'd1, 1'b0, 5'd0, 32'd2); tick();
        en = 0;
        checks += 3;
        if (alu_result !== 32'd3) begin errors++; $display("FAIL add_after_mult got %h want 3", alu_result); end
        if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL hi_hold got %h want ffffffff", hi); end
        if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL lo_hold got %h want ffffffeb", lo); end
    endtask

    task automatic test_branch_not_taken();
        branch_en = 1; branch = 1; pc = 32'h20; imm = 32'h40;
        tick(); branch_en = 0;
        checks += 2;
        if (pc_out !== 32'h20) begin errors++; $display("FAIL br_not_taken got %h want 00000020", pc_out); end
        if (branch_done !== 1) begin errors++; $display("FAIL br_nt_done got %b want 1", branch_done); end
    endtask

    task automatic test_back_to_back();
        en = 1;
        for (int i = 1; i <= 3; i++) begin
            set_op(4'd2, 32'(i * 10), 1'b0, 5'd0, 32'd1);
            tick();
            checks += 2;
            if (alu_result !== 32'(i * 10 + 1)) begin errors++; $display("FAIL b2b_res%0d got %h want %h", i, alu_result, 32'(i * 10 + 1)); end
            if (alu_done !== 1) begin errors++; $display("FAIL b2b_done%0d got %b want 1", i, alu_done); end
        end
        en = 0; tick();
        checks++;
        if (alu_done !== 0) begin errors++; $display("FAIL b2b_done_end got %b want 0", alu_done); end
    endtask

    task automatic test_coincide();
        // Previous result is nonzero; SUB 5-5 in the same cycle must not steer the branch.
        set_op(4'd6, 32'd5, 1'b0, 5'd0, 32'd5);
        en = 1; branch_en = 1; branch = 1; pc = 32'h100; imm = 32'h4;
        tick(); en = 0;
        checks += 2;
        if (pc_out !== 32'h100) begin errors++; $display("FAIL coincide_pc got %h want 00000100", pc_out); end
        if (alu_zero !== 1) begin errors++; $display("FAIL coincide_zero got %b want 1", alu_zero); end
        tick(); branch_en = 0;
        checks++;
        if (pc_out !== 32'h104) begin errors++; $display("FAIL after_coincide_pc got %h want 00000104", pc_out); end
    endtask

    task automatic test_div();
        en = 1;
        set_op(4'd8, 32'd3, 1'b0, 5'd0, 32'd5); tick();
`ifdef ALU_DIV_EN
        set_op(4'd9, 32'hFFFFFFF9, 1'b0, 5'd0, 32'd2); tick();
        checks += 3;
        if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        if (alu_result !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_res got %h want fffffffd", alu_result); end
        set_op(4'd9, 32'd9, 1'b0, 5'd0, 32'd0); tick();
        checks += 2;
        if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
        if (hi !== 32'd9) begin errors++; $display("FAIL div0_hi got %h want 9", hi); end
        set_op(4'd9, 32'h80000000, 1'b0, 5'd0, 32'hFFFFFFFF); tick();
        checks += 2;
        if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", lo); end
        if (hi !== 32'd0) begin errors++; $display("FAIL divmin_hi got %h want 0", hi); end
`else
        set_op(4'd9, 32'd9, 1'b0, 5'd0, 32'd3); tick();
        checks += 4;
        if (alu_result !== 0) begin errors++; $display("FAIL nodiv_res got %h want 0", alu_result); end
        if (alu_zero !== 1) begin errors++; $display("FAIL nodiv_zero got %b want 1", alu_zero); end
        if (hi !== 0) begin errors++; $display("FAIL nodiv_hi got %h want 0", hi); end
        if (lo !== 32'd15) begin errors++; $display("FAIL nodiv_lo got %h want 0000000f", lo); end
`endif
        en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_control  = 4'($urandom_range(0, 15));
            src_b        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            read_data1   = ($urandom_range(0, 3) == 0) ? src_b : $urandom;
            if ($urandom_range(0, 5) == 0) read_data1 = {1'b0, 31'h7FFFFFFF} - 32'($urandom_range(0, 1));
            shamt        = 5'($urandom);
            select_shamt = ($urandom_range(0, 3) == 0);
            en           = ($urandom_range(0, 3) != 0);
            branch_en    = ($urandom_range(0, 2) == 0);
            branch       = 1'($urandom);
            imm          = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : -32'($urandom_range(0, 64));
            pc           = $urandom;
            rst          = ($urandom_range(0, 59) == 0);
            tick();
            checks += 8;
            if (alu_result !== m_res) begin errors++; $display("FAIL rnd_result[%0d] got %h want %h", i, alu_result, m_res); end
            if (hi !== m_hi) begin errors++; $display("FAIL rnd_hi[%0d] got %h want %h", i, hi, m_hi); end
            if (lo !== m_lo) begin errors++; $display("FAIL rnd_lo[%0d] got %h want %h", i, lo, m_lo); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, overflow, m_ovf); end
            if (alu_zero !== m_zero) begin errors++; $display("FAIL rnd_zero[%0d] got %b want %b", i, alu_zero, m_zero); end
            if (alu_done !== m_done) begin errors++; $display("FAIL rnd_done[%0d] got %b want %b", i, alu_done, m_done); end
            if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc_out, m_pc); end
            if (branch_done !== m_bdone) begin errors++; $display("FAIL rnd_bdone[%0d] got %b want %b", i, branch_done, m_bdone); end
        end
        rst = 0; en = 0; branch_en = 0;
    endtask

    initial begin
        rst = 1; en = 0; branch_en = 0; branch = 0; imm = 0; pc = 0;
        set_op(4'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_add_overflow();
        test_sub_branch();
        test_shifts();
        test_mult_hold();
        test_branch_not_taken();
        test_back_to_back();
        test_coincide();
        test_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
